// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage core.
// Runs data-bus loads/stores through a req/ack handshake, stalls upstream
// while an access is outstanding and registers the MEM/WB write-back slot.
// Optional build macro: DBUS_TIMEOUT_EN enables an ack timeout with a
// sticky err_o flag. Without it, BUSY waits indefinitely for ack.
//
//   state | meaning
//   IDLE  | no access outstanding; ALU/pc4/ext results pass to WB in 1 cycle
//   BUSY  | data-bus request outstanding; upstream stalled until ack
module mem_access_stage #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [DW-1:0] aluc_i,
    input  logic [DW-1:0] rD2_i,
    input  logic [1:0]    rf_wsel_i,
    input  logic          ram_we_i,
    input  logic          rf_we_i,
    input  logic [4:0]    wR_i,
    input  logic [DW-1:0] pc4_i,
    input  logic [DW-1:0] ext_i,
    output logic          stall_o,
    output logic          dbus_req_o,
    output logic          dbus_we_o,
    output logic [AW-1:0] dbus_addr_o,
    output logic [DW-1:0] dbus_wdata_o,
    input  logic          dbus_ack_i,
    input  logic [DW-1:0] dbus_rdata_i,
    output logic          wb_valid_o,
    output logic          wb_we_o,
    output logic [4:0]    wb_wR_o,
    output logic [DW-1:0] wb_wd_o,
    output logic          err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          mem_op;
    logic          abort;
    logic [4:0]    hold_wR;
    logic          hold_we;
    logic [DW-1:0] alu_path_wd;

    assign mem_op = valid_i & (ram_we_i | (rf_wsel_i == 2'b01));

`ifdef DBUS_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       err;

    // Abort in the BUSY cycle whose missed ack would bring the count to
    // TIMEOUT; an ack in that same cycle takes priority.
    assign abort = (state == BUSY) & ~dbus_ack_i & (to_cnt == 8'(TIMEOUT - 1));
    assign err_o = err;

    // Counter is held at zero in IDLE so it starts clean on every BUSY entry.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            to_cnt <= '0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else if (!dbus_ack_i) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err <= 1'b0;
        end else if (abort) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign err_o          = 1'b0;
    assign unused_timeout = ^8'(TIMEOUT);
`endif

    // Non-memory write-back source; 01 (load) never reaches this path.
    always_comb begin
        alu_path_wd = aluc_i;
        case (rf_wsel_i)
            2'b10:   alu_path_wd = pc4_i;
            2'b11:   alu_path_wd = ext_i;
            default: alu_path_wd = aluc_i;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and stall; stall drops in the completion cycle so the
    // upstream stages advance on the same edge that retires the access.
    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall_o    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall_o = ~dbus_ack_i & ~abort;
                if (dbus_ack_i || abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus request, held destination info and the MEM/WB output slot.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_wdata_o <= '0;
            hold_wR      <= '0;
            hold_we      <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_wR_o      <= '0;
            wb_wd_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= ram_we_i;
                        dbus_addr_o  <= aluc_i[AW-1:0];
                        dbus_wdata_o <= rD2_i;
                        hold_wR      <= wR_i;
                        hold_we      <= rf_we_i;
                        wb_valid_o   <= 1'b0;
                        wb_we_o      <= 1'b0;
                    end else begin
                        wb_valid_o <= valid_i;
                        wb_we_o    <= valid_i & rf_we_i;
                        wb_wR_o    <= wR_i;
                        wb_wd_o    <= alu_path_wd;
                    end
                end
                BUSY: begin
                    if (dbus_ack_i) begin
                        dbus_req_o <= 1'b0;
                        wb_valid_o <= 1'b1;
                        wb_wR_o    <= hold_wR;
                        if (dbus_we_o) begin
                            wb_we_o <= 1'b0;
                            wb_wd_o <= '0;
                        end else begin
                            wb_we_o <= hold_we;
                            wb_wd_o <= dbus_rdata_i;
                        end
                    end else if (abort) begin
                        dbus_req_o <= 1'b0;
                        wb_valid_o <= 1'b1;
                        wb_we_o    <= 1'b0;
                        wb_wR_o    <= hold_wR;
                        wb_wd_o    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed steps followed by
// randomized instructions, checked against a transaction-level model.
module tb_mem_access_stage;

    localparam int TO_LIM = 4;
`ifdef DBUS_TIMEOUT_EN
    localparam int MODEL_TO = TO_LIM;
`else
    localparam int MODEL_TO = 1000000;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] aluc_i;
    logic [31:0] rD2_i;
    logic [1:0]  rf_wsel_i;
    logic        ram_we_i;
    logic        rf_we_i;
    logic [4:0]  wR_i;
    logic [31:0] pc4_i;
    logic [31:0] ext_i;
    logic        stall_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_wR_o;
    logic [31:0] wb_wd_o;
    logic        err_o;

    int   tests = 0;
    int   fails = 0;
    logic exp_err = 1'b0;

    mem_access_stage #(.DW(32), .AW(32), .TIMEOUT(TO_LIM)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .aluc_i(aluc_i),
        .rD2_i(rD2_i), .rf_wsel_i(rf_wsel_i), .ram_we_i(ram_we_i),
        .rf_we_i(rf_we_i), .wR_i(wR_i), .pc4_i(pc4_i), .ext_i(ext_i),
        .stall_o(stall_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
        .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_wR_o(wb_wR_o),
        .wb_wd_o(wb_wd_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction starting at posedge+1; returns at posedge+1 after
    // its write-back has been checked. lat = BUSY cycles before ack.
    task automatic do_op(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] ws, input logic sw, input logic rw,
                         input logic [4:0] r, input logic [31:0] p, input logic [31:0] e,
                         input int lat, input logic [31:0] rd, input string tag);
        logic        is_mem;
        logic        aborted;
        int          waits;
        logic [31:0] exp_wd;
        valid_i = v; aluc_i = a; rD2_i = d; rf_wsel_i = ws; ram_we_i = sw;
        rf_we_i = rw; wR_i = r; pc4_i = p; ext_i = e;
        dbus_ack_i = 1'($urandom_range(0, 1));
        dbus_rdata_i = $urandom;
        is_mem = v && (sw || ws == 2'b01);
        #1;
        chk({tag, ".stall_issue"}, 32'(stall_o), 32'(is_mem));
        @(posedge clk_i); #1;
        dbus_ack_i = 1'b0;
        if (!is_mem) begin
            exp_wd = (ws == 2'b10) ? p : (ws == 2'b11) ? e : a;
            chk({tag, ".wb_valid"}, 32'(wb_valid_o), 32'(v));
            chk({tag, ".wb_we"}, 32'(wb_we_o), 32'(v & rw));
            if (v) begin
                chk({tag, ".wb_wR"}, 32'(wb_wR_o), 32'(r));
                chk({tag, ".wb_wd"}, wb_wd_o, exp_wd);
            end
            chk({tag, ".req_idle"}, 32'(dbus_req_o), 32'd0);
        end else begin
            chk({tag, ".req"}, 32'(dbus_req_o), 32'd1);
            chk({tag, ".we"}, 32'(dbus_we_o), 32'(sw));
            chk({tag, ".addr"}, dbus_addr_o, a);
            chk({tag, ".wdata"}, dbus_wdata_o, d);
            chk({tag, ".wb_valid_busy"}, 32'(wb_valid_o), 32'd0);
            aborted = (lat >= MODEL_TO);
            waits = aborted ? MODEL_TO - 1 : lat;
            for (int k = 0; k < waits; k++) begin
                #1;
                chk({tag, ".stall_busy"}, 32'(stall_o), 32'd1);
                @(posedge clk_i); #1;
                chk({tag, ".req_hold"}, 32'(dbus_req_o), 32'd1);
                chk({tag, ".addr_hold"}, dbus_addr_o, a);
            end
            if (!aborted) begin
                dbus_ack_i = 1'b1;
                dbus_rdata_i = rd;
            end
            #1;
            chk({tag, ".stall_done"}, 32'(stall_o), 32'd0);
            @(posedge clk_i); #1;
            dbus_ack_i = 1'b0;
            dbus_rdata_i = $urandom;
            if (aborted) exp_err = 1'b1;
            chk({tag, ".req_drop"}, 32'(dbus_req_o), 32'd0);
            chk({tag, ".wb_valid"}, 32'(wb_valid_o), 32'd1);
            chk({tag, ".wb_wR"}, 32'(wb_wR_o), 32'(r));
            if (aborted || sw) begin
                chk({tag, ".wb_we"}, 32'(wb_we_o), 32'd0);
                chk({tag, ".wb_wd"}, wb_wd_o, 32'd0);
            end else begin
                chk({tag, ".wb_we"}, 32'(wb_we_o), 32'(rw));
                chk({tag, ".wb_wd"}, wb_wd_o, rd);
            end
        end
        chk({tag, ".err"}, 32'(err_o), 32'(exp_err));
    endtask

    initial begin
        rst_i = 1'b0; valid_i = 1'b0; aluc_i = '0; rD2_i = '0; rf_wsel_i = '0;
        ram_we_i = 1'b0; rf_we_i = 1'b0; wR_i = '0; pc4_i = '0; ext_i = '0;
        dbus_ack_i = 1'b0; dbus_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.req", 32'(dbus_req_o), 32'd0);
        chk("rst.addr", dbus_addr_o, 32'd0);
        chk("rst.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst.wb_wd", wb_wd_o, 32'd0);
        chk("rst.err", 32'(err_o), 32'd0);
        chk("rst.stall", 32'(stall_o), 32'd0);
        rst_i = 1'b1;

        do_op(1, 32'h10, 32'h0, 2'b00, 0, 1, 5'd5, 32'h0, 32'h0, 0, 32'h0, "alu");
        do_op(1, 32'h1000, 32'h0, 2'b01, 0, 1, 5'd7, 32'h0, 32'h0, 3, 32'hCAFEF00D, "load3");
        do_op(1, 32'h2004, 32'h12345678, 2'b00, 1, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0, "store0");
        do_op(1, 32'h3000, 32'h0, 2'b01, 0, 1, 5'd9, 32'h0, 32'h0, 1, 32'h55AA55AA, "b2b_load");
        do_op(1, 32'h0, 32'h0, 2'b10, 0, 1, 5'd10, 32'h84, 32'h0, 0, 32'h0, "b2b_pc4");
        chk("b2b.no_dup_req", 32'(dbus_req_o), 32'd0);
        do_op(1, 32'h0, 32'h0, 2'b11, 0, 0, 5'd3, 32'h0, 32'hFFFF8000, 0, 32'h0, "ext");
        do_op(0, 32'h0, 32'h0, 2'b01, 1, 1, 5'd4, 32'h0, 32'h0, 0, 32'h0, "bubble");

        // Reset in the middle of an outstanding load.
        valid_i = 1'b1; aluc_i = 32'h4000; rf_wsel_i = 2'b01; ram_we_i = 1'b0;
        rf_we_i = 1'b1; wR_i = 5'd12;
        @(posedge clk_i); #1;
        chk("midrst.req_busy", 32'(dbus_req_o), 32'd1);
        rst_i = 1'b0; valid_i = 1'b0;
        @(posedge clk_i); #1;
        exp_err = 1'b0;
        chk("midrst.req", 32'(dbus_req_o), 32'd0);
        chk("midrst.addr", dbus_addr_o, 32'd0);
        chk("midrst.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("midrst.wb_we", 32'(wb_we_o), 32'd0);
        chk("midrst.wb_wR", 32'(wb_wR_o), 32'd0);
        chk("midrst.wb_wd", wb_wd_o, 32'd0);
        chk("midrst.stall", 32'(stall_o), 32'd0);
        rst_i = 1'b1;
        do_op(1, 32'h1004, 32'h0, 2'b01, 0, 1, 5'd13, 32'h0, 32'h0, 2, 32'h0BADBEEF, "post_rst_load");

`ifdef DBUS_TIMEOUT_EN
        do_op(1, 32'h5000, 32'h0, 2'b01, 0, 1, 5'd14, 32'h0, 32'h0, 10, 32'h0, "timeout");
        do_op(1, 32'h77, 32'h0, 2'b00, 0, 1, 5'd15, 32'h0, 32'h0, 0, 32'h0, "after_timeout");
`endif

        for (int i = 0; i < 60; i++) begin
            logic v, sw, rw;
            logic [1:0] ws;
            v  = ($urandom_range(0, 7) != 0);
            sw = ($urandom_range(0, 3) == 0);
            rw = 1'($urandom_range(0, 1));
            ws = 2'($urandom_range(0, 3));
            do_op(v, $urandom, $urandom, ws, sw, rw, 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom_range(0, 5), $urandom, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage core; consumes the EX/MEM pipeline register outputs (ALU result, store data, write-back select, RAM write enable).
- Performs data-bus load/store through a req/ack handshake and stalls upstream while an access is outstanding.
- Registers the selected write-back value into the MEM/WB outputs feeding the register file.

Parameters:
DW, 32, data width of ALU result, store data, bus data and write-back data
AW, 32, data-bus address width; low AW bits of aluc_i
TIMEOUT, 255, cycles without ack before abort (used only with DBUS_TIMEOUT_EN); 8-bit counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-low
valid_i  in  1  EX/MEM slot holds a live instruction
aluc_i  in  DW  ALU result / memory address
rD2_i  in  DW  store data
rf_wsel_i  in  2  write-back select: 00 ALU, 01 load data, 10 pc4_i, 11 ext_i
ram_we_i  in  1  store instruction
rf_we_i  in  1  register-file write enable
wR_i  in  5  destination register index
pc4_i  in  DW  PC+4
ext_i  in  DW  immediate
stall_o  out  1  hold EX/MEM and upstream stages (combinational)
dbus_req_o  out  1  data-bus request
dbus_we_o  out  1  1 = write
dbus_addr_o  out  AW  bus address
dbus_wdata_o  out  DW  bus write data
dbus_ack_i  in  1  slave completion, one cycle per request
dbus_rdata_i  in  DW  read data, valid with ack
wb_valid_o  out  1  MEM/WB slot valid
wb_we_o  out  1  register-file write enable
wb_wR_o  out  5  destination index
wb_wd_o  out  DW  write-back data
err_o  out  1  sticky bus timeout flag (0 when DBUS_TIMEOUT_EN is undefined)

Behaviour:
- Reset: rst_i low at a rising edge forces state IDLE. All registered outputs go to 0: dbus_*, wb_*, err_o, timeout counter.
- Memory op: valid_i & (ram_we_i | rf_wsel_i==01).
- States: IDLE, BUSY.
- IDLE, no memory op:
  - wb_valid_o<=valid_i, wb_we_o<=valid_i&rf_we_i, wb_wR_o<=wR_i.
  - wb_wd_o<=mux(rf_wsel_i: ALU/pc4/ext); 01 is unreachable here.
  - stall_o=0. Latency 1 cycle.
- IDLE, memory op at cycle N:
  - stall_o=1 in cycle N.
  - Latch dbus_addr_o<=aluc_i[AW-1:0], dbus_wdata_o<=rD2_i, dbus_we_o<=ram_we_i, dbus_req_o<=1.
  - Latch wR/we/wsel into internal holding registers.
  - wb_valid_o<=0. Next state BUSY.
- BUSY:
  - dbus_req_o, addr, wdata and we are held stable until ack.
  - stall_o = ~dbus_ack_i.
- BUSY with dbus_ack_i=1 at cycle M:
  - dbus_req_o<=0, state<=IDLE, wb_valid_o<=1, wb_wR_o from the held register.
  - Load: wb_we_o<=held rf_we, wb_wd_o<=dbus_rdata_i.
  - Store: wb_we_o<=0, wb_wd_o<=0.
  - stall_o=0 in cycle M, so upstream advances at the M edge.
- Zero-wait slave (ack in first BUSY cycle): minimum load/store latency is 2 cycles from valid_i.
- The instruction held in EX/MEM during BUSY is never re-issued, because the state is BUSY until the ack edge.
- dbus_ack_i while IDLE is ignored.
- valid_i=0 in IDLE: wb_valid_o<=0, wb_we_o<=0; other wb fields are don't-care but still registered.
- Addresses pass through unmodified (no alignment check); word access only.
- Reset mid-BUSY: the request is dropped. The slave must tolerate req falling without ack.

Optional Feature:
- Macro DBUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT: abort the access. dbus_req_o<=0, state IDLE, wb_valid_o<=1, wb_we_o<=0, wb_wd_o<=0.
  - err_o<=1, sticky until reset; stall_o=0 that cycle.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter; BUSY waits indefinitely; err_o tied 0.

Test Plan:
- ALU op: valid_i=1, rf_wsel_i=00, aluc_i=0x00000010, wR_i=5, rf_we_i=1 -> next cycle wb_valid_o=1, wb_we_o=1, wb_wR_o=5, wb_wd_o=0x10, stall_o=0 throughout.
- Load, 3-cycle slave: aluc_i=0x1000, rf_wsel_i=01, rdata=0xCAFEF00D -> stall_o=1 for 4 cycles; dbus_addr_o=0x1000 and we=0 held stable; after ack, wb_wd_o=0xCAFEF00D and wb_we_o=1.
- Store, zero-wait slave: ram_we_i=1, aluc_i=0x2004, rD2_i=0x12345678 -> one BUSY cycle with dbus_we_o=1, wdata=0x12345678; then wb_valid_o=1, wb_we_o=0.
- Back-to-back: load followed by an ALU op (rf_wsel=10, pc4_i=0x84) -> the load write-back precedes wb_wd_o=0x84 by exactly 1 cycle; no duplicate load request.
- Reset mid-BUSY: drive rst_i=0 during BUSY -> next edge dbus_req_o=0, all wb_*=0, stall_o=0; resume with a clean load.
- DBUS_TIMEOUT_EN with TIMEOUT=4, no ack -> abort after 4 BUSY cycles, err_o=1 (sticky), wb_we_o=0; a subsequent ALU op completes normally.
